// File: rtl/frame_aligner_8b.sv
// Frame aligner for a 5-lane 10-bit deserializer: hunts for a lane-0 comma, verifies all-lane comma frames, then forwards aligned frames.
// Optional lock-loss statistics counter is enabled by defining FRAME_ALIGNER_STATS_EN.

module frame_aligner_8b #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MAX_GAP  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strb,
    input  logic [49:0] encode,
    input  logic [39:0] datin,
    output logic [39:0] dout,
    output logic        dout_vld,
    output logic        dout_k,
    output logic        locked,
    output logic        align_err,
    output logic [15:0] err_cnt
);

    localparam int unsigned LANES     = 5;
    localparam int unsigned SYM_W     = 10;
    localparam int unsigned DATA_W    = 40;
    localparam int unsigned PHASE_W   = 4;
    localparam int unsigned GAP_W     = 8;
    localparam int unsigned GAP_CMP_W = GAP_W + 1;
    localparam int unsigned VCNT_W    = $clog2(LOCK_CNT + 1);

    localparam logic [SYM_W-1:0]     COMMA_P    = 10'b0011111010;
    localparam logic [SYM_W-1:0]     COMMA_N    = 10'b1100000101;
    localparam logic [PHASE_W-1:0]   LAST_PHASE = PHASE_W'(9);
    localparam logic [GAP_CMP_W-1:0] GAP_LIMIT  = GAP_CMP_W'(MAX_GAP);
    localparam logic [VCNT_W-1:0]    VCNT_LOCK  = VCNT_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                strb_q, strb_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;
    logic                dout_k_q, dout_k_d;
    logic                locked_q, locked_d;
    logic                align_err_q, align_err_d;

    logic [LANES-1:0]     comma_c;
    logic                 all_comma_c;
    logic                 no_comma_c;
    logic [PHASE_W-1:0]   phase_inc_c;
    logic [VCNT_W-1:0]    vcnt_inc_c;
    logic [GAP_CMP_W-1:0] gap_inc_c;

    // Per-lane comma detection on the raw shift registers
    always_comb begin
        comma_c = '0;
        for (int k = 0; k < LANES; k++) begin
            comma_c[k] = (encode[k*SYM_W +: SYM_W] == COMMA_P) ||
                         (encode[k*SYM_W +: SYM_W] == COMMA_N);
        end
    end

    assign all_comma_c = &comma_c;
    assign no_comma_c  = ~|comma_c;
    assign phase_inc_c = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
    assign vcnt_inc_c  = vcnt_q + VCNT_W'(1);
    assign gap_inc_c   = {1'b0, gap_q} + GAP_CMP_W'(1);

    // Next-state and output logic; strb_q marks a cycle where encode/datin hold a new bit
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        vcnt_d      = vcnt_q;
        gap_d       = gap_q;
        strb_d      = strb;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        dout_k_d    = dout_k_q;
        align_err_d = 1'b0;

        case (state_q)
            HUNT: begin
                if (strb_q) begin
                    if (comma_c[0]) begin
                        state_d = VERIFY;
                        phase_d = PHASE_W'(1);
                        vcnt_d  = VCNT_W'(1);
                    end else begin
                        phase_d = phase_inc_c;
                    end
                end
            end
            VERIFY: begin
                if (strb_q) begin
                    phase_d = phase_inc_c;
                    if (phase_q == '0) begin
                        if (all_comma_c) begin
                            vcnt_d = vcnt_inc_c;
                            if (vcnt_inc_c == VCNT_LOCK) begin
                                state_d = LOCKED;
                                vcnt_d  = '0;
                                gap_d   = '0;
                            end
                        end else begin
                            state_d = HUNT;
                            vcnt_d  = '0;
                        end
                    end
                end
            end
            LOCKED: begin
                if (strb_q) begin
                    phase_d = phase_inc_c;
                    if (phase_q == '0) begin
                        if (all_comma_c) begin
                            gap_d      = '0;
                            dout_d     = datin;
                            dout_k_d   = 1'b1;
                            dout_vld_d = 1'b1;
                        end else if (no_comma_c && (gap_inc_c <= GAP_LIMIT)) begin
                            gap_d      = gap_inc_c[GAP_W-1:0];
                            dout_d     = datin;
                            dout_k_d   = 1'b0;
                            dout_vld_d = 1'b1;
                        end else begin
                            // Gap overflow or lane skew: the frame is dropped
                            state_d     = HUNT;
                            gap_d       = '0;
                            align_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
                vcnt_d  = '0;
                gap_d   = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            phase_q     <= '0;
            vcnt_q      <= '0;
            gap_q       <= '0;
            strb_q      <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_k_q    <= 1'b0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            vcnt_q      <= vcnt_d;
            gap_q       <= gap_d;
            strb_q      <= strb_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_k_q    <= dout_k_d;
            locked_q    <= locked_d;
            align_err_q <= align_err_d;
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign dout_k    = dout_k_q;
    assign locked    = locked_q;
    assign align_err = align_err_q;

`ifdef FRAME_ALIGNER_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of lock losses
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (align_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_aligner_8b.sv
// Scoreboard bench for frame_aligner_8b: a serial bit-stream generator per lane feeds the DUT and a frame-level model,
// whose predicted frames and lock losses are checked by an independent monitor.

module tb_frame_aligner_8b;

    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned MAX_GAP  = 255;
    localparam logic [9:0]  C0 = 10'b0011111010;
    localparam logic [9:0]  C1 = 10'b1100000101;
`ifdef FRAME_ALIGNER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strb;
    logic [49:0] encode;
    logic [39:0] datin;
    logic [39:0] dout;
    logic        dout_vld;
    logic        dout_k;
    logic        locked;
    logic        align_err;
    logic [15:0] err_cnt;

    frame_aligner_8b #(.LOCK_CNT(LOCK_CNT), .MAX_GAP(MAX_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .strb(strb), .encode(encode), .datin(datin),
        .dout(dout), .dout_vld(dout_vld), .dout_k(dout_k), .locked(locked),
        .align_err(align_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int vld_seen = 0;
    int err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model: mode 0 searching, 1 confirming, 2 tracking
    int          m_mode = 0;
    int          m_pos  = 0;
    int          m_run  = 0;
    int          m_gap  = 0;
    int          m_errs = 0;
    logic [40:0] vq[$];
    logic [15:0] eq[$];

    function automatic bit is_comma(input logic [9:0] s);
        return (s == C0) || (s == C1);
    endfunction

    function automatic void model_lose();
        m_mode = 0;
        if (m_errs < 65535) m_errs++;
        eq.push_back(STATS ? 16'(m_errs) : 16'd0);
    endfunction

    function automatic void model_eval(input logic [49:0] enc, input logic [39:0] dat);
        int  n = 0;
        bit  at_frame;
        for (int k = 0; k < 5; k++) n += int'(is_comma(enc[k*10 +: 10]));
        if (m_mode == 0) begin
            if (is_comma(enc[9:0])) begin
                m_mode = 1;
                m_pos  = 1;
                m_run  = 1;
            end
        end else begin
            at_frame = (m_pos == 0);
            m_pos    = (m_pos + 1) % 10;
            if (at_frame && m_mode == 1) begin
                if (n == 5) begin
                    m_run++;
                    if (m_run == int'(LOCK_CNT)) begin
                        m_mode = 2;
                        m_gap  = 0;
                    end
                end else begin
                    m_mode = 0;
                end
            end else if (at_frame && m_mode == 2) begin
                if (n == 5) begin
                    m_gap = 0;
                    vq.push_back({1'b1, dat});
                end else if (n == 0 && m_gap + 1 <= int'(MAX_GAP)) begin
                    m_gap++;
                    vq.push_back({1'b0, dat});
                end else begin
                    model_lose();
                end
            end
        end
    endfunction

    // Upstream deserializer emulation: one shift register per lane, datin presented one cycle after strb
    logic [9:0]  sr[5];
    logic [39:0] cur_dat;
    bit          pend_s;
    logic [49:0] pend_enc;
    logic [39:0] pend_dat;

    function automatic logic [49:0] cur_enc();
        logic [49:0] e;
        for (int k = 0; k < 5; k++) e[k*10 +: 10] = sr[k];
        return e;
    endfunction

    task automatic tick(input bit s);
        @(negedge clk);
        encode = pend_enc;
        datin  = pend_dat;
        if (pend_s) model_eval(pend_enc, pend_dat);
        strb     = s;
        pend_s   = s;
        pend_enc = cur_enc();
        pend_dat = cur_dat;
    endtask

    task automatic flush();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic send_bit(input logic [4:0] bits, input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) tick(1'b0);
        for (int k = 0; k < 5; k++) sr[k] = {sr[k][8:0], bits[k]};
        tick(1'b1);
    endtask

    task automatic send_frame(input logic [49:0] syms, input logic [39:0] dat, input bit gaps);
        logic [4:0] bits;
        cur_dat = dat;
        for (int b = 9; b >= 0; b--) begin
            for (int k = 0; k < 5; k++) bits[k] = syms[k*10 + b];
            send_bit(bits, gaps);
        end
    endtask

    function automatic logic [9:0] rand_sym();
        logic [9:0] s;
        s = 10'($urandom());
        while (is_comma(s)) s = 10'($urandom());
        return s;
    endfunction

    function automatic logic [49:0] comma_syms(input bit mix);
        logic [49:0] s;
        for (int k = 0; k < 5; k++) s[k*10 +: 10] = (mix && $urandom_range(0, 1) == 1) ? C1 : C0;
        return s;
    endfunction

    function automatic logic [49:0] data_syms();
        logic [49:0] s;
        for (int k = 0; k < 5; k++) s[k*10 +: 10] = rand_sym();
        return s;
    endfunction

    function automatic logic [39:0] rand40();
        return 40'({$urandom(), $urandom()});
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        strb   = 1'b0;
        pend_s = 1'b0;
        m_mode = 0; m_pos = 0; m_run = 0; m_gap = 0; m_errs = 0;
        vq.delete();
        eq.delete();
        for (int k = 0; k < 5; k++) sr[k] = '0;
        cur_dat  = '0;
        pend_enc = '0;
        pend_dat = '0;
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_dout_vld", 64'(dout_vld), 64'd0);
        check("rst_dout_k", 64'(dout_k), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_align_err", 64'(align_err), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_sequence();
        int v0 = vld_seen;
        repeat (3) send_frame(comma_syms(1'b0), rand40(), 1'b0);
        flush();
        check("lock_early", 64'(locked), 64'd0);
        send_frame(comma_syms(1'b0), rand40(), 1'b0);
        flush();
        check("lock_4th", 64'(locked), 64'd1);
        check("no_vld_prelock", 64'(vld_seen - v0), 64'd0);
    endtask

    // Monitor: compares every DUT presentation against the scoreboard queues
    always @(posedge clk) begin
        logic [40:0] exp_f;
        #1;
        if (rst_n) begin
            check("locked", 64'(locked), 64'(m_mode == 2));
            if (dout_vld) begin
                vld_seen++;
                if (vq.size() == 0) begin
                    check("dout_vld_unexpected", 64'(dout_vld), 64'd0);
                end else begin
                    exp_f = vq.pop_front();
                    check("dout", 64'(dout), 64'(exp_f[39:0]));
                    check("dout_k", 64'(dout_k), 64'(exp_f[40]));
                end
            end else if (vq.size() != 0) begin
                check("dout_vld_missing", 64'(dout_vld), 64'd1);
                void'(vq.pop_front());
            end
            if (align_err) begin
                err_seen++;
                if (eq.size() == 0) check("align_err_unexpected", 64'(align_err), 64'd0);
                else check("err_cnt", 64'(err_cnt), 64'(eq.pop_front()));
            end else if (eq.size() != 0) begin
                check("align_err_missing", 64'(align_err), 64'd1);
                void'(eq.pop_front());
            end
        end
    end

    initial begin
        logic [49:0] syms;
        int          e0;
        int          r;
        rst_n = 1'b0; strb = 1'b0; encode = '0; datin = '0;
        do_reset();

        // Aligned comma frames at one strobe per cycle
        lock_sequence();

        // Known data frame while locked
        send_frame(data_syms(), 40'h0123456789, 1'b0);
        flush();
        check("data_vld", 64'(dout_vld), 64'd1);
        check("data_dout", 64'(dout), 64'h0123456789);
        check("data_k", 64'(dout_k), 64'd0);

        // Lane skew: commas on lanes 0-3 only
        syms = comma_syms(1'b0);
        syms[49:40] = rand_sym();
        send_frame(syms, rand40(), 1'b0);
        flush();
        check("skew_err", 64'(align_err), 64'd1);
        check("skew_locked", 64'(locked), 64'd0);
        check("skew_no_vld", 64'(dout_vld), 64'd0);
        check("skew_err_cnt", 64'(err_cnt), STATS ? 64'd1 : 64'd0);
        tick(1'b0);
        check("skew_err_once", 64'(align_err), 64'd0);

        // Lane-0 comma at bit offset 3, then a failing verify frame
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send_bit((i % 2 == 0) ? 5'b10101 : 5'b01010, 1'b0);
        syms = data_syms();
        syms[9:0] = C0;
        send_frame(syms, rand40(), 1'b0);
        send_frame(data_syms(), rand40(), 1'b0);
        flush();
        check("verify_fail_locked", 64'(locked), 64'd0);
        check("verify_fail_no_err", 64'(err_seen - e0), 64'd0);

        // Gap counter: comma at frame 255 keeps lock, then 256 plain frames lose it
        repeat (5) send_frame(comma_syms(1'b0), rand40(), 1'b0);
        flush();
        check("relock", 64'(locked), 64'd1);
        e0 = err_seen;
        repeat (254) send_frame(data_syms(), rand40(), 1'b0);
        send_frame(comma_syms(1'b1), rand40(), 1'b0);
        repeat (255) send_frame(data_syms(), rand40(), 1'b0);
        flush();
        check("gap_255_locked", 64'(locked), 64'd1);
        check("gap_255_no_err", 64'(err_seen - e0), 64'd0);
        send_frame(data_syms(), rand40(), 1'b0);
        flush();
        check("gap_256_err", 64'(align_err), 64'd1);
        check("gap_256_unlock", 64'(locked), 64'd0);

        // Reset mid-frame while locked, then relock from scratch
        repeat (5) send_frame(comma_syms(1'b0), rand40(), 1'b1);
        send_frame(data_syms(), rand40(), 1'b0);
        syms = data_syms();
        for (int b = 9; b >= 6; b--) send_bit({syms[40+b], syms[30+b], syms[20+b], syms[10+b], syms[b]}, 1'b0);
        @(negedge clk);
        do_reset();
        lock_sequence();

        // Randomized mix of comma, data and skewed frames with strobe gaps
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 8));
            if (r < 5) begin
                syms = comma_syms(1'b1);
            end else if (r < 8) begin
                syms = data_syms();
            end else begin
                syms = comma_syms(1'b1);
                for (int k = 0; k < 5; k++)
                    if ($urandom_range(0, 1) == 1) syms[k*10 +: 10] = rand_sym();
            end
            send_frame(syms, rand40(), 1'b1);
        end
        flush();
        repeat (3) tick(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
